lshift_seq: RTL and testbench
=============================

// Module: lshift_seq
// PURPOSE
//  Multi-cycle left-shift sequencer. Accepts a DATA_W operand and a shift amount,
//  then drives a shift-by-2 step stage repeatedly (plus one final shift-by-1 for
//  odd amounts) until the full shift is done. Sits beside the jump-target path of
//  the datapath, where variable shifts are rare and area matters more than latency.
// PARAMETERS
//  DATA_W   26  operand width (din_i)
//  OUT_W    32  result width; operand is zero-extended to OUT_W before shifting
//  SHAMT_W   5  shift-amount width; legal amounts 0..2**SHAMT_W-1
// PORTS
//  clk      in   1        single clock; all state changes on posedge clk
//  reset    in   1        synchronous, active-low reset (0 = reset)
//  start_i  in   1        request; accepted only when start_i && ready_o
//  ready_o  out  1        1 only in IDLE
//  din_i    in   DATA_W   operand, sampled on accept
//  shamt_i  in   SHAMT_W  shift amount, sampled on accept
//  busy_o   out  1        1 in SHIFT
//  valid_o  out  1        1 in DONE; dout_o/ovf_o are valid
//  ack_i    in   1        consumer acknowledge; completes the op when valid_o && ack_i
//  dout_o   out  OUT_W    result = ({zero-ext din} << shamt) truncated to OUT_W
//  ovf_o    out  1        1 if any 1 bit was shifted out past bit OUT_W-1
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, ready_o=1, busy_o=0, valid_o=0,
//   dout_o=0, ovf_o=0, cnt=0. Reset wins over every other input, including mid-op.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   IDLE : on start_i: acc<=zero-ext(din_i), cnt<=shamt_i, ovf<=0;
//          go to DONE if shamt_i==0, else to SHIFT. No start_i: stay in IDLE.
//   SHIFT: each cycle, if cnt>=2: acc<=acc<<2, cnt-=2; if cnt==1: acc<<=1, cnt=0.
//          ovf |= OR of the bits shifted out this cycle. Go to DONE when the
//          post-step cnt is 0.
//   DONE : valid_o=1; hold dout_o/ovf_o stable until ack_i; on ack_i go to IDLE.
//  Latency: accept in cycle N -> valid_o=1 in cycle N+1+ceil(shamt/2).
//  start_i outside IDLE is ignored (no queue). A request is not accepted in the
//   same cycle as ack_i; the earliest next accept is the cycle after return to IDLE.
//  ack_i outside DONE is ignored. din_i/shamt_i may change freely after accept.
//  dout_o resets to 0, then always shows acc. It is defined only while valid_o=1.
//  Shifts >= OUT_W give dout_o=0 and ovf_o=1 if din_i!=0.
//  At most one ready_o/busy_o/valid_o is high in any cycle.
// STRUCTURE
//  Package shift_pkg: typedef enum logic[1:0] {S_IDLE,S_SHIFT,S_DONE} shseq_state_t;
//   default localparams DATA_W/OUT_W/SHAMT_W, shared with the datapath.
//  Sub-module lshift2_step: combinational, param W, amt (0/1/2) ->
//   {out_bits[1:0], y = x<<amt}; one instance. Controller plus registers in lshift_seq.
// TESTING
//  1 reset=0 for 2 cycles mid-SHIFT -> next cycle IDLE, ready_o=1, valid_o=0, dout_o=0.
//  2 din=26'h3FFFFFF, shamt=2 -> valid_o at N+2, dout_o=32'h0FFFFFFC, ovf_o=0
//    (matches legacy 28-bit shift-by-2, zero-extended).
//  3 din=26'h0000001, shamt=0 -> valid_o at N+1, dout_o=32'h00000001; shamt=7 ->
//    valid_o at N+5, dout_o=32'h00000080.
//  4 din=26'h2000000, shamt=7 -> dout_o=32'h00000000, ovf_o=1; shamt=6 -> dout_o=32'h80000000, ovf_o=0.
//  5 start_i held high during SHIFT/DONE; ack_i delayed 5 cycles -> one op only,
//    dout_o stable through wait, re-accept only after return to IDLE.
//  6 random din/shamt, 500 ops, random ack delays -> scoreboard vs (zext<<shamt),
//    latency formula checked, state one-hot asserted.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and default widths for the left-shift sequencer
// and the jump-target datapath beside it.
package shift_pkg;

  localparam int DATA_W  = 26;
  localparam int OUT_W   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } shseq_state_t;

endpackage

// File: rtl/lshift2_step.sv
// Combinational shift-left step by 0, 1 or 2 bits.
// Reports the bits pushed out past the MSB.
module lshift2_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [1:0]   amt,
  output logic [1:0]   out_bits,
  output logic [W-1:0] y
);

  always_comb begin
    out_bits = '0;
    y        = x;
    case (amt)
      2'd1: begin
        out_bits = {1'b0, x[W-1]};
        y        = {x[W-2:0], 1'b0};
      end
      2'd2: begin
        out_bits = x[W-1:W-2];
        y        = {x[W-3:0], 2'b00};
      end
      default: begin
        out_bits = '0;
        y        = x;
      end
    endcase
  end

endmodule

// File: rtl/lshift_seq.sv
// Multi-cycle left-shift sequencer: zero-extends the operand and
// shifts it two bits per cycle, one extra bit for odd amounts.
module lshift_seq
  import shift_pkg::*;
#(
  parameter int DATA_W  = shift_pkg::DATA_W,
  parameter int OUT_W   = shift_pkg::OUT_W,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  output logic               ready_o,
  input  logic [DATA_W-1:0]  din_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               valid_o,
  input  logic               ack_i,
  output logic [OUT_W-1:0]   dout_o,
  output logic               ovf_o
);

  shseq_state_t       state;
  shseq_state_t       state_nx;
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   acc_step;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] cnt_nx;
  logic               ovf;
  logic [1:0]         amt;
  logic [1:0]         out_bits;

  // Step size: two while at least two remain, then the odd leftover bit.
  always_comb begin
    amt = 2'd0;
    if (state == S_SHIFT) begin
      if (cnt > SHAMT_W'(1)) begin
        amt = 2'd2;
      end else begin
        amt = {1'b0, cnt[0]};
      end
    end
  end

  assign cnt_nx = cnt - SHAMT_W'(amt);

  lshift2_step #(
    .W (OUT_W)
  ) u_step (
    .x        (acc),
    .amt      (amt),
    .out_bits (out_bits),
    .y        (acc_step)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nx = (shamt_i == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_nx == '0) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (ack_i) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    unique case (1'b1)
      (state == S_IDLE):  ready_o = 1'b1;
      (state == S_SHIFT): busy_o  = 1'b1;
      (state == S_DONE):  valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == S_IDLE && start_i) begin
        acc <= OUT_W'(din_i);
        cnt <= shamt_i;
        ovf <= 1'b0;
      end else if (state == S_SHIFT) begin
        acc <= acc_step;
        cnt <= cnt_nx;
        ovf <= ovf | (|out_bits);
      end
    end
  end

  assign dout_o = acc;
  assign ovf_o  = ovf;

endmodule

// File: tb/tb_lshift_seq.sv
// Scoreboard bench for lshift_seq: directed corner cases plus
// random operands against an arithmetic reference model.
module tb_lshift_seq;
  import shift_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start_i = 1'b0;
  logic               ack_i = 1'b0;
  logic [DATA_W-1:0]  din_i = '0;
  logic [SHAMT_W-1:0] shamt_i = '0;
  logic               ready_o;
  logic               busy_o;
  logic               valid_o;
  logic [OUT_W-1:0]   dout_o;
  logic               ovf_o;

  lshift_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .ready_o (ready_o),
    .din_i   (din_i),
    .shamt_i (shamt_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .ack_i   (ack_i),
    .dout_o  (dout_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] dout;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Reference: full-width shift, low word is the result, high word overflow.
  function automatic exp_t model(input logic [DATA_W-1:0] d, input int s,
                                 input int acc_cyc);
    exp_t e;
    logic [63:0] w;
    w = 64'(d) << s;
    e.dout = w[OUT_W-1:0];
    e.ovf  = |w[63:OUT_W];
    e.due  = acc_cyc + 1 + (s + 1) / 2;
    return e;
  endfunction

  logic             seen = 1'b0;
  logic [OUT_W-1:0] held_d;
  logic             held_o;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      chk("onehot", 64'($countones({ready_o, busy_o, valid_o})), 64'd1);
      if (valid_o && !seen) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("dout", 64'(dout_o), 64'(e.dout));
          chk("ovf", 64'(ovf_o), 64'(e.ovf));
          chk("latency", 64'(cyc), 64'(e.due));
        end
        seen   = 1'b1;
        held_d = dout_o;
        held_o = ovf_o;
      end else if (valid_o) begin
        chk("dout_stable", 64'(dout_o), 64'(held_d));
        chk("ovf_stable", 64'(ovf_o), 64'(held_o));
      end
      if (valid_o && ack_i) seen = 1'b0;
    end
  end

  int ack_fixed = -1;
  int ack_d;

  initial begin : acker
    forever begin
      @(posedge clk);
      #1;
      if (reset && valid_o && !ack_i) begin
        ack_d = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 4));
        repeat (ack_d) begin
          @(posedge clk);
          #1;
        end
        ack_i = 1'b1;
        @(posedge clk);
        #1;
        ack_i = 1'b0;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(posedge clk);
    #1;
    while (!ready_o && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = ready_o;
    if (!ok) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [DATA_W-1:0] d, input int s,
                       input bit hold);
    bit ok;
    int n = 0;
    wait_ready(ok);
    if (!ok) return;
    start_i = 1'b1;
    din_i   = d;
    shamt_i = SHAMT_W'(s);
    q.push_back(model(d, s, cyc));
    @(posedge clk);
    #1;
    din_i   = DATA_W'($urandom);
    shamt_i = SHAMT_W'($urandom);
    if (hold) begin
      while (!(valid_o && ack_i) && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!(valid_o && ack_i)) chk("hold_timeout", 64'd0, 64'd1);
    end
    start_i = 1'b0;
  endtask

  initial begin : main
    bit ok;
    int n;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_dout", 64'(dout_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);
    reset = 1'b1;

    issue(26'h3FFFFFF, 2, 1'b0);
    issue(26'h0000001, 0, 1'b0);
    issue(26'h0000001, 7, 1'b0);
    issue(26'h2000000, 7, 1'b0);
    issue(26'h2000000, 6, 1'b0);
    issue(26'h1234567, 31, 1'b0);

    ack_fixed = 5;
    issue(26'h0ABCDEF, 9, 1'b1);
    @(posedge clk);
    #1;
    chk("reaccept_ready", 64'(ready_o), 64'd1);
    ack_fixed = -1;
    issue(26'h0000003, 1, 1'b0);

    wait_ready(ok);
    start_i = 1'b1;
    din_i   = 26'h3FFFFFF;
    shamt_i = 5'd31;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy_o), 64'd1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_dout", 64'(dout_o), 64'd0);

    for (int i = 0; i < 500; i++) begin
      issue(DATA_W'($urandom), int'($urandom_range(0, 31)), 1'b0);
    end

    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
